fetch_queue: RTL

Instruction fetch stage sitting directly downstream of the program counter and upstream of decode. Holds its own fetch address, issues single-outstanding reads to instruction memory, and buffers returned words with their addresses in a small prefetch queue. Decode pops words over a valid/ready handshake. A redirect from the PC load path flushes the queue and restarts fetch at the new address.

---
 rtl/fetch_queue.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: fetch stage with one outstanding memory read and a
// small prefetch queue. Define FETCH_DISCARD_CNT_EN for discard_cnt.
module fetch_queue #(
  parameter int WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect,
  input  logic [WIDTH-1:0]      redirect_addr,
  output logic                  mem_req,
  output logic [WIDTH-1:0]      mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  ins_valid,
  input  logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] ins_data,
  output logic [WIDTH-1:0]      ins_pc
`ifdef FETCH_DISCARD_CNT_EN
  ,
  output logic [7:0]            discard_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } state_t;

  state_t state, state_d;

  logic [WIDTH-1:0]      fetch_addr;
  logic [WIDTH-1:0]      hold_addr;
  logic [WIDTH-1:0]      pc_q   [DEPTH];
  logic [DATA_WIDTH-1:0] word_q [DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_pop;
  logic                  pop;
  logic                  push;
  logic                  drop;

  // A pop in a redirect cycle is ignored: the flush wins.
  assign pop = ins_valid & ins_ready & ~redirect;
  assign count_pop = count - (pop ? ONE : '0);

  // Next state; a request only starts when a slot is free for its reply.
  always_comb begin
    state_d = state;
    push = 1'b0;
    drop = 1'b0;
    unique case (state)
      IDLE: begin
        if (!redirect && count_pop < FULL) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          if (redirect) begin
            drop = 1'b1;
            state_d = IDLE;
          end else begin
            push = 1'b1;
            if (count_pop >= FULL - ONE) begin
              state_d = IDLE;
            end
          end
        end else if (redirect) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (mem_ack) begin
          drop = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Fetch address, stale-request address and queue storage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_addr <= RESET_ADDR;
      hold_addr <= RESET_ADDR;
      head <= '0;
      tail <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i] <= '0;
        word_q[i] <= '0;
      end
    end else if (redirect) begin
      fetch_addr <= redirect_addr;
      head <= '0;
      tail <= '0;
      count <= '0;
      if (state == REQ) begin
        hold_addr <= fetch_addr;
      end
    end else begin
      if (push) begin
        pc_q[tail] <= fetch_addr;
        word_q[tail] <= mem_rdata;
        tail <= tail + PW'(1);
        fetch_addr <= fetch_addr + WIDTH'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      count <= count_pop + (push ? ONE : '0);
    end
  end

  assign mem_req = (state != IDLE);
  assign mem_addr = (state == DISCARD) ? hold_addr : fetch_addr;
  assign ins_valid = (count != '0);
  assign ins_data = ins_valid ? word_q[head] : '0;
  assign ins_pc = ins_valid ? pc_q[head] : '0;

`ifdef FETCH_DISCARD_CNT_EN
  logic [8:0] dsum;

  assign dsum = {1'b0, discard_cnt}
              + 9'(redirect ? count : '0)
              + 9'(drop);

  // Saturating count of flushed entries and dropped replies.
  always_ff @(posedge clk) begin
    if (!reset) begin
      discard_cnt <= '0;
    end else begin
      discard_cnt <= dsum[8] ? 8'hFF : dsum[7:0];
    end
  end
`endif

endmodule
